// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Lock supervisor and reset sequencer for the refclk -> 200 MHz PLL wrapper.
//   Pulses the PLL reset, qualifies the synchronized lock indication, releases
//   the downstream system reset after a stable-lock window and re-arms the PLL
//   on loss of lock, keeping a saturating loss count and a sticky timeout flag.
//   Single clock domain (refclk), synchronous active-low reset (rst).
//   Optional build macro: LOCK_GLITCH_FILTER_EN -- when defined, a loss in RUN
//   is declared only after GLITCH_CYCLES consecutive low synchronized-lock cycles.
module pll_lock_sequencer #(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOSS_CNT_W          = 8,
    parameter int unsigned GLITCH_CYCLES       = 4
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  retrigger,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic                  timeout_err
);

    // Phase counter is sized for the longest of the three timed phases; every
    // phase leaves before its terminal count, so the counter never wraps.
    localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                        PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ?
                                        CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    if (SYNC_STAGES < 2 || GLITCH_CYCLES < 1 || PLL_RST_CYCLES < 1 ||
        LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("pll_lock_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_locked_s;
    logic                    w_loss;
    logic                    w_timeout;
    logic                    r_pll_rst;
    logic                    r_ready;
    logic [LOSS_CNT_W-1:0]   r_loss_count;
    logic                    r_timeout_err;

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int unsigned      GL_W    = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [GL_W-1:0]  GL_LAST = GL_W'(GLITCH_CYCLES - 1);

    logic [GL_W-1:0] r_glitch;
    logic [GL_W-1:0] w_glitch_nxt;
`endif

    assign w_locked_s  = r_sync[SYNC_STAGES-1];

    assign pll_rst     = r_pll_rst;
    assign sys_rst_n   = r_ready;
    assign ready       = r_ready;
    assign loss_count  = r_loss_count;
    assign timeout_err = r_timeout_err;

    // Bring the asynchronous PLL lock indication into the refclk domain.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Sequencer state and phase counter.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_state <= RESET_PLL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef LOCK_GLITCH_FILTER_EN
    // Consecutive low-lock cycles seen while running.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_glitch <= '0;
        end else begin
            r_glitch <= w_glitch_nxt;
        end
    end
`endif

    // Next-state, counter, loss and timeout decode.
    // Loss and timeout events are still recorded when retrigger arrives on the
    // same cycle; retrigger only decides where the sequencer goes next.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_loss      = 1'b0;
        w_timeout   = 1'b0;
`ifdef LOCK_GLITCH_FILTER_EN
        w_glitch_nxt = '0;
`endif
        unique case (r_state)
            RESET_PLL: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                w_timeout = !w_locked_s && (r_cnt == TMO_LAST);
                if (retrigger || w_timeout) begin
                    w_state_nxt = RESET_PLL;
                    w_cnt_nxt   = '0;
                end else if (w_locked_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end
            end
            STABLE: begin
                if (retrigger) begin
                    w_state_nxt = RESET_PLL;
                    w_cnt_nxt   = '0;
                end else if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
`ifdef LOCK_GLITCH_FILTER_EN
                if (!w_locked_s) begin
                    if (r_glitch == GL_LAST) begin
                        w_loss = 1'b1;
                    end else begin
                        w_glitch_nxt = r_glitch + GL_W'(1);
                    end
                end
`else
                w_loss = !w_locked_s;
`endif
                if (w_loss || retrigger) begin
                    w_state_nxt = RESET_PLL;
                end
            end
            default: begin
                w_state_nxt = RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Registered Moore outputs (decoded from the next state so they move on the
    // same edge as the state) plus the sticky loss counter and timeout flag.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_pll_rst     <= 1'b1;
            r_ready       <= 1'b0;
            r_loss_count  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pll_rst <= (w_state_nxt == RESET_PLL);
            r_ready   <= (w_state_nxt == RUN);
            if (w_loss && (r_loss_count != '1)) begin
                r_loss_count <= r_loss_count + LOSS_CNT_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Directed scenarios with hand-derived expectations plus a randomized run.
//   A behavioural model (phase + time-in-phase + lock history queue) predicts
//   every output on every cycle; one compare process checks the DUT against it.
module tb_pll_lock_sequencer;

    localparam int unsigned SYNC_STAGES         = 2;
    localparam int unsigned PLL_RST_CYCLES      = 4;
    localparam int unsigned LOCK_STABLE_CYCLES  = 8;
    localparam int unsigned LOCK_TIMEOUT_CYCLES = 32;
    localparam int unsigned LOSS_CNT_W          = 2;
    localparam int unsigned GLITCH_CYCLES       = 4;

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int LOSS_RUN = GLITCH_CYCLES;
    localparam int DROP     = GLITCH_CYCLES + 1;
`else
    localparam int LOSS_RUN = 1;
    localparam int DROP     = 1;
`endif
    localparam int LOSS_LAT = SYNC_STAGES + LOSS_RUN;

    logic                  refclk = 1'b0;
    logic                  rst;
    logic                  pll_locked;
    logic                  retrigger;
    logic                  pll_rst;
    logic                  sys_rst_n;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] loss_count;
    logic                  timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_sequencer #(
        .SYNC_STAGES        (SYNC_STAGES),
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .LOSS_CNT_W         (LOSS_CNT_W),
        .GLITCH_CYCLES      (GLITCH_CYCLES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .retrigger  (retrigger),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .loss_count (loss_count),
        .timeout_err(timeout_err)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_ARM    = 0;  // PLL held in reset
    localparam int PH_WAIT   = 1;  // waiting for lock
    localparam int PH_QUAL   = 2;  // lock being qualified
    localparam int PH_RUN    = 3;  // system released

    int   m_phase = PH_ARM;
    int   m_age   = 0;     // cycles spent in the current phase, this one included
    int   m_low   = 0;     // consecutive low synchronized-lock cycles while running
    int   m_loss  = 0;
    bit   m_terr  = 1'b0;
    bit   m_valid = 1'b0;
    logic q[$];            // pll_locked samples still travelling through the synchronizer

    task automatic enter(input int ph);
        m_phase = ph;
        m_age   = 0;
        m_low   = 0;
    endtask

    always @(posedge refclk) begin
        logic ls;
        logic lost;
        if (!rst) begin
            enter(PH_ARM);
            m_loss  = 0;
            m_terr  = 1'b0;
            q.delete();
            for (int i = 0; i < int'(SYNC_STAGES); i++) q.push_back(1'b0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls = q.pop_front();
            q.push_back(pll_locked);
            m_age++;
            case (m_phase)
                PH_ARM: begin
                    if (m_age == int'(PLL_RST_CYCLES)) enter(PH_WAIT);
                end
                PH_WAIT: begin
                    if (!ls && m_age == int'(LOCK_TIMEOUT_CYCLES)) begin
                        m_terr = 1'b1;
                        enter(PH_ARM);
                    end else if (retrigger) begin
                        enter(PH_ARM);
                    end else if (ls) begin
                        enter(PH_QUAL);
                    end
                end
                PH_QUAL: begin
                    if (retrigger)                                enter(PH_ARM);
                    else if (!ls)                                 enter(PH_WAIT);
                    else if (m_age == int'(LOCK_STABLE_CYCLES))   enter(PH_RUN);
                end
                default: begin
                    m_low = ls ? 0 : m_low + 1;
                    lost  = (m_low >= LOSS_RUN);
                    if (lost && m_loss < (1 << LOSS_CNT_W) - 1) m_loss++;
                    if (lost || retrigger) enter(PH_ARM);
                end
            endcase
        end
    end

    // Every cycle after the first reset edge the outputs are defined.
    always @(negedge refclk) begin
        if (m_valid) begin
            check("cycle_outputs {pll_rst,sys_rst_n,ready,loss_count,timeout_err}",
                  {pll_rst, sys_rst_n, ready, loss_count, timeout_err},
                  {m_phase == PH_ARM, m_phase == PH_RUN, m_phase == PH_RUN,
                   LOSS_CNT_W'(m_loss), m_terr});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        rst = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b1;
    endtask

    task automatic count_pll_rst(input logic lvl, input int max, output int n);
        n = 0;
        while (pll_rst === lvl && n < max) begin
            n++;
            @(negedge refclk);
        end
    endtask

    task automatic wait_ready(input string name, input logic lvl, input int max, output int n);
        n = 0;
        while (ready !== lvl && n < max) begin
            @(negedge refclk);
            n++;
        end
        check(name, ready, lvl);
    endtask

    initial begin
        int n;
        int exp_loss[5] = '{1, 2, 3, 3, 3};
        int seg_left;

        rst        = 1'b0;
        pll_locked = 1'b0;
        retrigger  = 1'b0;
        repeat (2) @(negedge refclk);

        check("reset_pll_rst",     pll_rst,     1);
        check("reset_sys_rst_n",   sys_rst_n,   0);
        check("reset_ready",       ready,       0);
        check("reset_loss_count",  loss_count,  0);
        check("reset_timeout_err", timeout_err, 0);

        // 1: no lock -> 4-cycle pulse, 32-cycle wait, timeout, pulse again
        do_reset();
        count_pll_rst(1'b1, 100, n);  check("s1_rst_pulse", n, 4);
        count_pll_rst(1'b0, 100, n);  check("s1_wait_len", n, 32);
        check("s1_timeout_err", timeout_err, 1);
        count_pll_rst(1'b1, 100, n);  check("s1_rst_pulse2", n, 4);
        check("s1_sys_rst_n", sys_rst_n, 0);

        // 2: lock 10 cycles into WAIT_LOCK -> ready 11 edges after first sample
        do_reset();
        count_pll_rst(1'b1, 100, n);
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        wait_ready("s2_ready", 1'b1, 50, n);
        check("s2_lock_to_ready", n, 11);
        check("s2_sys_rst_n", sys_rst_n, 1);
        check("s2_loss_count", loss_count, 0);
        check("s2_timeout_err", timeout_err, 0);

        // 3: one-cycle drop in RUN
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
`ifdef LOCK_GLITCH_FILTER_EN
        repeat (10) @(negedge refclk);
        check("s3_filtered_ready", ready, 1);
        check("s3_filtered_loss", loss_count, 0);
`else
        n = 1;
        while (ready === 1'b1 && n < 20) begin
            @(negedge refclk);
            n++;
        end
        check("s3_loss_latency", n, 3);
        check("s3_loss_count", loss_count, 1);
        count_pll_rst(1'b1, 100, n);  check("s3_rst_pulse", n, 4);
        wait_ready("s3_relock", 1'b1, 100, n);
`endif

        // 4: drop during qualification -> full window restarts, no loss
        do_reset();
        pll_locked = 1'b0;
        count_pll_rst(1'b1, 100, n);
        pll_locked = 1'b1;
        repeat (6) @(negedge refclk);
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (3) @(negedge refclk);
        check("s4_no_early_release", ready, 0);
        n = 3;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge refclk);
            n++;
        end
        check("s4_drop_to_ready", n, 11);
        check("s4_loss_count", loss_count, 0);

        // 5: five losses saturate at 3
        do_reset();
        pll_locked = 1'b1;
        wait_ready("s5_first_ready", 1'b1, 100, n);
        for (int k = 0; k < 5; k++) begin
            pll_locked = 1'b0;
            repeat (DROP) @(negedge refclk);
            pll_locked = 1'b1;
            wait_ready("s5_loss_seen", 1'b0, 50, n);
            check("s5_loss_count", loss_count, exp_loss[k]);
            wait_ready("s5_relock", 1'b1, 100, n);
        end

        // 5b: retrigger coinciding with a loss counts once
        do_reset();
        pll_locked = 1'b1;
        wait_ready("s5b_ready", 1'b1, 100, n);
        pll_locked = 1'b0;
        for (int i = 0; i < LOSS_LAT; i++) begin
            if (i == DROP) pll_locked = 1'b1;
            if (i == LOSS_LAT - 1) retrigger = 1'b1;
            @(negedge refclk);
        end
        retrigger = 1'b0;
        check("s5b_retrig_loss_ready", ready, 0);
        check("s5b_retrig_loss_count", loss_count, 1);
        wait_ready("s5b_relock", 1'b1, 100, n);

        // 5c: plain retrigger is not a loss; a second one inside RESET_PLL is ignored
        retrigger = 1'b1;
        @(negedge refclk);
        check("s5c_retrig_pll_rst", pll_rst, 1);
        check("s5c_retrig_no_loss", loss_count, 1);
        @(negedge refclk);
        retrigger = 1'b0;
        count_pll_rst(1'b1, 100, n);
        check("s5c_retrig_ignored_in_reset", n, 3);

        // 6: synchronous reset mid-RUN with loss_count=2
        do_reset();
        pll_locked = 1'b1;
        wait_ready("s6_ready", 1'b1, 100, n);
        for (int k = 0; k < 2; k++) begin
            pll_locked = 1'b0;
            repeat (DROP) @(negedge refclk);
            pll_locked = 1'b1;
            wait_ready("s6_loss_seen", 1'b0, 50, n);
            wait_ready("s6_relock", 1'b1, 100, n);
        end
        check("s6_loss_before_rst", loss_count, 2);
        rst = 1'b0;
        @(negedge refclk);
        check("s6_pll_rst", pll_rst, 1);
        check("s6_sys_rst_n", sys_rst_n, 0);
        check("s6_ready", ready, 0);
        check("s6_loss_count", loss_count, 0);
        check("s6_timeout_err", timeout_err, 0);
        rst = 1'b1;

        // Randomized lock behaviour, retriggers and occasional resets.
        seg_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                seg_left   = pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
            end
            seg_left--;
            retrigger = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 600) != 0);
            @(negedge refclk);
        end
        rst       = 1'b1;
        retrigger = 1'b0;
        @(negedge refclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got %0d checks required completion", n_checks);
        $fatal(1);
    end

endmodule
